// File: rtl/instr_data_mem_responder.sv
// Fixed-latency req/ack memory responder with a word-addressed RAM and error flagging.
// Optional byte-lane write enables are built in when MEMRESP_BYTE_ENABLE_EN is defined.
module instr_data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
`ifdef MEMRESP_BYTE_ENABLE_EN
    input  logic [3:0]  be_i,
`endif
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        busy_o
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic        w_txn_we;
    logic [31:0] w_txn_addr;
    logic [31:0] w_txn_wdata;
    logic [3:0]  w_txn_be;
    logic [3:0]  w_be_in;
    logic [AW-1:0] w_idx;
    logic        w_bad;
    logic        w_enter_resp;
    logic        w_mem_we;
    logic        w_ack_d;
    logic        w_err_d;
    logic        w_busy_d;

`ifdef MEMRESP_BYTE_ENABLE_EN
    assign w_be_in = be_i;
`else
    assign w_be_in = 4'hF;
`endif

    // With LATENCY=1 RESP is entered at the accepting edge, so the live inputs are used.
    assign w_txn_we    = (r_state == IDLE) ? we_i    : r_we;
    assign w_txn_addr  = (r_state == IDLE) ? addr_i  : r_addr;
    assign w_txn_wdata = (r_state == IDLE) ? wdata_i : r_wdata;
    assign w_txn_be    = (r_state == IDLE) ? w_be_in : r_be;

    assign w_idx = w_txn_addr[AW+1:2];
    assign w_bad = (w_txn_addr[1:0] != 2'b00) ||
                   ({2'b00, w_txn_addr[31:2]} >= 32'(DEPTH_WORDS));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (req_i) w_next_state = (LATENCY == 1) ? RESP : WAIT;
            WAIT: if (r_cnt == 4'd1) w_next_state = RESP;
            RESP: w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_enter_resp = (w_next_state == RESP) && (r_state != RESP);
        w_ack_d      = w_enter_resp;
        w_err_d      = w_enter_resp && w_bad;
        w_busy_d     = (w_next_state != IDLE);
        w_mem_we     = rst_i && w_enter_resp && w_txn_we && !w_bad;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
        end else begin
            case (r_state)
                IDLE: if (req_i) begin
                    r_cnt   <= 4'(LATENCY - 1);
                    r_we    <= we_i;
                    r_addr  <= addr_i;
                    r_wdata <= wdata_i;
                    r_be    <= w_be_in;
                end
                WAIT: r_cnt <= r_cnt - 4'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ack_o   <= 1'b0;
            err_o   <= 1'b0;
            busy_o  <= 1'b0;
            rdata_o <= '0;
        end else begin
            ack_o  <= w_ack_d;
            err_o  <= w_err_d;
            busy_o <= w_busy_d;
            if (w_enter_resp) begin
                if (w_bad) rdata_o <= '0;
                else if (!w_txn_we) rdata_o <= r_mem[w_idx];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_mem_we) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (w_txn_be[b]) r_mem[w_idx][8*b +: 8] <= w_txn_wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_instr_data_mem_responder.sv
// Scoreboard bench for instr_data_mem_responder: a driver issues requests and predicts
// responses from a word-array model; a negedge monitor compares every ack and busy_o.
module tb_instr_data_mem_responder;

    localparam int unsigned L = 3;
    localparam int unsigned D = 256;
`ifdef MEMRESP_BYTE_ENABLE_EN
    localparam bit BE_EN = 1'b1;
`else
    localparam bit BE_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  be = 4'hF;
    logic        ack;
    logic [31:0] rdata;
    logic        err;
    logic        busy;

    instr_data_mem_responder #(.DEPTH_WORDS(D), .LATENCY(L)) dut (
        .clk_i   (clk),
        .rst_i   (rst_n),
        .req_i   (req),
        .we_i    (we),
        .addr_i  (addr),
        .wdata_i (wdata),
`ifdef MEMRESP_BYTE_ENABLE_EN
        .be_i    (be),
`endif
        .ack_o   (ack),
        .rdata_o (rdata),
        .err_o   (err),
        .busy_o  (busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        bit          dc;
        int unsigned acc;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mdl_mem [D];
    bit          mdl_known [D];
    logic [31:0] mdl_last = '0;
    bit          mdl_last_known = 1'b1;
    int unsigned last_acc = 0;
    bit          have_acc = 1'b0;
    bit          in_rst = 1'b1;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: busy_o is high from the accepting edge until the edge that ends the ack cycle.
    always @(negedge clk) begin
        exp_t e;
        if (in_rst) begin
            chk("rst_ack", 32'(ack), 32'd0);
            chk("rst_err", 32'(err), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_rdata", rdata, 32'd0);
        end else begin
            chk("busy", 32'(busy),
                32'(have_acc && cyc >= last_acc && cyc <= last_acc + L - 1));
            if (ack) begin
                if (q.size() == 0) begin
                    chk("unexpected_ack", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    // ack is registered at edge acc+L-1, so the edge acc+L samples it high
                    chk("ack_cycle", cyc, e.acc + L - 1);
                    chk("err", 32'(err), 32'(e.err));
                    if (!e.dc) chk("rdata", rdata, e.rdata);
                end
            end
        end
    end

    function automatic exp_t predict(input logic w, input logic [31:0] a,
                                     input logic [31:0] d, input logic [3:0] b);
        exp_t        e;
        int unsigned idx;
        logic [3:0]  eff;
        e.acc = 0;
        eff = BE_EN ? b : 4'hF;
        if (a[1:0] != 2'b00 || a[31:2] >= D) begin
            e.err = 1'b1; e.rdata = '0; e.dc = 1'b0;
            mdl_last = '0; mdl_last_known = 1'b1;
        end else begin
            idx = int'(a[31:2]);
            e.err = 1'b0;
            if (!w) begin
                e.rdata = mdl_mem[idx]; e.dc = !mdl_known[idx];
                mdl_last = mdl_mem[idx]; mdl_last_known = mdl_known[idx];
            end else begin
                for (int i = 0; i < 4; i++)
                    if (eff[i]) mdl_mem[idx][8*i +: 8] = d[8*i +: 8];
                if (eff == 4'hF) mdl_known[idx] = 1'b1;
                e.rdata = mdl_last; e.dc = !mdl_last_known;
            end
        end
        return e;
    endfunction

    // Entered and left at posedge+2; keep=1 holds req high with junk during WAIT/RESP.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] b, input bit keep);
        exp_t e;
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
        @(posedge clk); #1;
        e = predict(w, a, d, b);
        e.acc = cyc;
        q.push_back(e);
        last_acc = cyc; have_acc = 1'b1;
        #1;
        repeat (L) begin
            if (keep) begin
                req = 1'b1; we = 1'($urandom); addr = $urandom; wdata = $urandom;
                be = 4'($urandom);
            end else begin
                req = 1'b0;
            end
            @(posedge clk); #2;
        end
    endtask

    task automatic enter_reset();
        rst_n = 1'b0; in_rst = 1'b1; have_acc = 1'b0;
        mdl_last = '0; mdl_last_known = 1'b1;
    endtask

    task automatic leave_reset();
        rst_n = 1'b1; in_rst = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        int unsigned r;
        for (int i = 0; i < int'(D); i++) mdl_known[i] = 1'b0;

        // Reset held with a pending request; first acceptance at first edge after release
        @(posedge clk); #2;
        enter_reset();
        req = 1'b1; we = 1'b0; addr = 32'h4;
        repeat (5) begin @(posedge clk); #2; end
        leave_reset();
        issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
        issue(1'b0, 32'h10, 32'h0, 4'hF, 1'b0);

        // Error responses, then no aliasing onto word 0
        issue(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 1'b0);
        issue(1'b0, 32'h13, 32'h0, 4'hF, 1'b0);
        issue(1'b1, 32'h400, 32'h12345678, 4'hF, 1'b0);
        issue(1'b0, 32'h0, 32'h0, 4'hF, 1'b0);
        issue(1'b0, 32'h3FC, 32'h0, 4'hF, 1'b0);

        // Write aborted by reset one cycle into WAIT
        issue(1'b1, 32'h20, 32'h11111111, 4'hF, 1'b0);
        req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h22222222; be = 4'hF;
        @(posedge clk); #1;
        last_acc = cyc; have_acc = 1'b1;
        #1; req = 1'b0;
        @(posedge clk); #2;
        enter_reset();
        repeat (2) begin @(posedge clk); #2; end
        leave_reset();
        issue(1'b0, 32'h20, 32'h0, 4'hF, 1'b0);

        // Byte-lane write (full-word write when the feature is absent)
        issue(1'b1, 32'h30, 32'h11111111, 4'hF, 1'b0);
        issue(1'b1, 32'h30, 32'hAABBCCDD, 4'b0011, 1'b0);
        issue(1'b0, 32'h30, 32'h0, 4'hF, 1'b0);
        issue(1'b1, 32'h30, 32'h55667788, 4'b0000, 1'b0);
        issue(1'b0, 32'h30, 32'h0, 4'hF, 1'b0);

        // Random traffic over a preloaded window, req held high with junk while busy
        for (int i = 0; i < 16; i++) issue(1'b1, 32'(i * 4), $urandom, 4'hF, 1'b1);
        for (int i = 0; i < 48; i++) begin
            r = $urandom_range(0, 99);
            if (r < 70)      a = 32'($urandom_range(0, 15) * 4);
            else if (r < 85) a = 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
            else             a = $urandom | 32'h400;
            issue(1'($urandom), a, $urandom, 4'($urandom), 1'($urandom));
        end
        req = 1'b0;

        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) chk("drain", 32'(q.size()), 32'd0);
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

endmodule
